ub_stream_reader: RTL

UB_STREAM_READER -- requirements
Module: ub_stream_reader

---
 rtl/tpu_ub_pkg.sv | 14 +
 rtl/ub_rd_fifo.sv | 75 +++++++
 rtl/ub_stream_reader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tpu_ub_pkg.sv
// Shared unified-buffer definitions: default UB geometry and the reader state encoding.
package tpu_ub_pkg;

    localparam int UB_DATA_WIDTH = 256;
    localparam int UB_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } ub_rd_state_t;

endpackage

// File: rtl/ub_rd_fifo.sv
// Output FIFO for the UB stream reader: synchronous, show-ahead head, simultaneous push/pop,
// with occupancy and free-count outputs and a synchronous flush.
module ub_rd_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] free
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign do_push = push && !flush && (count_q != CNT_FULL);
    assign do_pop  = pop && !flush && (count_q != '0);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;
    assign free     = CNT_FULL - count_q;

endmodule

// File: rtl/ub_stream_reader.sv
// Streams a command's word range out of the unified buffer in wrap-safe chunks through an output FIFO.
// Define UB_READER_TIMEOUT_EN to add the beat-starvation timeout and the sticky err_timeout flag.
module ub_stream_reader
    import tpu_ub_pkg::*;
#(
    parameter int DATA_WIDTH = UB_DATA_WIDTH,
    parameter int ADDR_WIDTH = UB_ADDR_WIDTH,
    parameter int CHUNK      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH:0]   cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_count,
    output logic                  ub_rd_en,
    output logic [ADDR_WIDTH:0]   ub_rd_addr,
    output logic [ADDR_WIDTH:0]   ub_rd_count,
    input  logic [DATA_WIDTH-1:0] ub_rd_data,
    input  logic                  ub_rd_valid,
    input  logic                  ub_busy,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  done,
    output logic                  err_timeout
);
    localparam int AW    = ADDR_WIDTH;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] A_ONE     = AW1'(1);
    localparam logic [AW:0] CHUNK_MAX = AW1'(CHUNK);
    localparam logic [AW:0] BANK_SPAN = AW1'(1) << AW;

    ub_rd_state_t state_q, state_d;
    logic [AW:0] cur_addr_q, cur_addr_d, remaining_q, remaining_d;
    logic [AW:0] chunk_q, chunk_d, beat_cnt_q, beat_cnt_d;
    logic [AW:0] ub_rd_addr_q, ub_rd_addr_d, ub_rd_count_q, ub_rd_count_d;
    logic        ub_rd_en_q, ub_rd_en_d, done_q, done_d;
    logic [AW:0] wrap_room, chunk_sz;
    logic [CNT_W-1:0] fifo_count, fifo_free;
    logic        fifo_push, fifo_pop, fifo_flush, push_last, head_last, issue_ok;
    logic [DATA_WIDTH:0] head_word;

`ifdef UB_READER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    // A request never runs past the end of the bank, so its addresses stay contiguous for the UB.
    always_comb begin
        wrap_room = BANK_SPAN - {1'b0, cur_addr_q[AW-1:0]};
        chunk_sz  = remaining_q;
        if (chunk_sz > CHUNK_MAX) chunk_sz = CHUNK_MAX;
        if (chunk_sz > wrap_room) chunk_sz = wrap_room;
    end

    assign issue_ok  = !ub_busy && (32'(fifo_free) >= 32'(chunk_sz));
    assign fifo_push = (state_q == WAIT) && ub_rd_valid;
    assign push_last = (remaining_q - beat_cnt_q) == A_ONE;
    assign m_valid   = (fifo_count != '0);
    assign fifo_pop  = m_valid && m_ready;
    assign head_last = head_word[DATA_WIDTH];

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        chunk_d       = chunk_q;
        beat_cnt_d    = beat_cnt_q;
        ub_rd_en_d    = 1'b0;
        ub_rd_addr_d  = ub_rd_addr_q;
        ub_rd_count_d = ub_rd_count_q;
        done_d        = 1'b0;
        fifo_flush    = 1'b0;
`ifdef UB_READER_TIMEOUT_EN
        err_d    = err_q;
        to_cnt_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_count;
`ifdef UB_READER_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (cmd_count == '0) done_d = 1'b1;
                    else                 state_d = REQ;
                end
            end
            REQ: begin
                if (issue_ok) begin
                    ub_rd_en_d    = 1'b1;
                    ub_rd_addr_d  = cur_addr_q;
                    ub_rd_count_d = chunk_sz;
                    chunk_d       = chunk_sz;
                    beat_cnt_d    = '0;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (ub_rd_valid) begin
                    if (beat_cnt_q + A_ONE == chunk_q) begin
                        cur_addr_d  = {cur_addr_q[AW], cur_addr_q[AW-1:0] + chunk_q[AW-1:0]};
                        remaining_d = remaining_q - chunk_q;
                        beat_cnt_d  = '0;
                        state_d     = (remaining_q == chunk_q) ? DRAIN : REQ;
                    end else begin
                        beat_cnt_d = beat_cnt_q + A_ONE;
                    end
                end
`ifdef UB_READER_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
`endif
            end
            DRAIN: begin
                if (fifo_pop && head_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            chunk_q       <= '0;
            beat_cnt_q    <= '0;
            ub_rd_en_q    <= 1'b0;
            ub_rd_addr_q  <= '0;
            ub_rd_count_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            chunk_q       <= chunk_d;
            beat_cnt_q    <= beat_cnt_d;
            ub_rd_en_q    <= ub_rd_en_d;
            ub_rd_addr_q  <= ub_rd_addr_d;
            ub_rd_count_q <= ub_rd_count_d;
            done_q        <= done_d;
        end
    end

`ifdef UB_READER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    ub_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data ({push_last, ub_rd_data}),
        .pop       (fifo_pop),
        .pop_data  (head_word),
        .count     (fifo_count),
        .free      (fifo_free)
    );

    assign cmd_ready   = (state_q == IDLE);
    assign ub_rd_en    = ub_rd_en_q;
    assign ub_rd_addr  = ub_rd_addr_q;
    assign ub_rd_count = ub_rd_count_q;
    assign m_data      = head_word[DATA_WIDTH-1:0];
    // Head contents are undefined while empty, so last is only meaningful with valid.
    assign m_last      = m_valid && head_last;
    assign done        = done_q;

endmodule
